mux_sel_pipe: RTL and testbench

Parametrised N:1 channel multiplexer with a registered output stage and valid/ready handshakes. It generalises the team's combinational 8:1 data-select mux to configurable channel count and data width. It adds two select modes: a software-loaded fixed select and a round-robin scan across valid channels. It sits between N producer channels and one consumer and provides one-cycle registered latency with full throughput.

---
 rtl/mux_sel_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/mux_sel_pipe.sv | 109 ++++++++++
 tb/tb_mux_sel_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the N:1 channel select multiplexer.
package mux_sel_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_SCAN  = 1'b1
    } mode_e;

    // Cyclic successor of a channel index within 0..nch-1.
    function automatic int unsigned next_rr_idx(input int unsigned idx, input int unsigned nch);
        return (idx + 32'd1 >= nch) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority picker: first requesting channel strictly after ptr, wrapping.
module rr_pick
    import mux_sel_pkg::*;
#(
    parameter int unsigned NCH  = 8,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        logic [SELW-1:0] idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = ptr;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = SELW'(next_rr_idx(32'(idx), NCH));
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// N:1 channel mux with fixed/round-robin select, valid/ready handshakes and
// a single registered output stage (one-cycle latency, full throughput).
module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int unsigned NCH  = 8,
    parameter int unsigned W    = 1,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel_in,
    input  logic              sel_load,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    mode_e           mode_c;
    logic [W-1:0]    chan_data [NCH];
    logic [SELW-1:0] scan_idx;
    logic            scan_any;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            can_load;
    logic            xfer;

    logic [SELW-1:0] sel_q,   sel_d;
    logic [SELW-1:0] rr_q,    rr_d;
    logic [W-1:0]    data_q,  data_d;
    logic [SELW-1:0] chan_q,  chan_d;
    logic            valid_q, valid_d;

    assign mode_c = mode_e'(mode);

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign chan_data[c] = in_data[c*W +: W];
    end

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (rr_q),
        .gnt_idx (scan_idx),
        .gnt_any (scan_any)
    );

    // Grant and handshake; in_ready never depends on in_data.
    always_comb begin
        can_load = !valid_q || out_ready;
        gnt_idx  = (mode_c == MODE_SCAN) ? scan_idx : sel_q;
        gnt_any  = (mode_c == MODE_SCAN) ? scan_any : 1'b1;
        in_ready = '0;
        if (gnt_any && can_load) begin
            in_ready[gnt_idx] = 1'b1;
        end
        xfer = gnt_any && can_load && in_valid[gnt_idx];
    end

    // Next state for select, RR pointer and output register.
    always_comb begin
        sel_d   = sel_q;
        rr_d    = rr_q;
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (sel_load && (32'(sel_in) < NCH)) begin
            sel_d = sel_in;
        end
        if (xfer && (mode_c == MODE_SCAN)) begin
            rr_d = gnt_idx;
        end
        if (xfer) begin
            data_d  = chan_data[gnt_idx];
            chan_d  = gnt_idx;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            rr_q    <= SELW'(NCH - 1);
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed literal checks on an 8x1 instance and a
// behavioural model compared every cycle against a randomised 5x16 instance.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- NCH=8, W=1 instance ----------------
    logic       rst8_n;
    logic [7:0] d8, v8, rdy8;
    logic       mode8, sel_load8, or8, od8, ov8;
    logic [2:0] sel_in8, oc8;

    mux_sel_pipe #(.NCH(8), .W(1)) u8 (
        .clk(clk), .rst_n(rst8_n), .in_data(d8), .in_valid(v8), .in_ready(rdy8),
        .mode(mode8), .sel_in(sel_in8), .sel_load(sel_load8),
        .out_data(od8), .out_chan(oc8), .out_valid(ov8), .out_ready(or8)
    );

    // ---------------- NCH=5, W=16 instance ----------------
    logic        rst5_n;
    logic [79:0] d5;
    logic [4:0]  v5, rdy5;
    logic        mode5, sel_load5, or5, ov5;
    logic [2:0]  sel_in5, oc5;
    logic [15:0] od5;

    mux_sel_pipe #(.NCH(5), .W(16)) u5 (
        .clk(clk), .rst_n(rst5_n), .in_data(d5), .in_valid(v5), .in_ready(rdy5),
        .mode(mode5), .sel_in(sel_in5), .sel_load(sel_load5),
        .out_data(od5), .out_chan(oc5), .out_valid(ov5), .out_ready(or5)
    );

    // Behavioural model of the 5-channel instance.
    int          m_sel, m_rr, m_oc;
    logic        m_ov;
    logic [15:0] m_od;
    logic        chk5_en = 1'b0;

    function automatic int m_grant();
        if (!mode5) return m_sel;
        for (int k = 1; k <= 5; k++) begin
            int c;
            c = (m_rr + k) % 5;
            if (v5[c[2:0]]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst5_n) begin
        if (!rst5_n) begin
            m_sel <= 0;
            m_rr  <= 4;
            m_ov  <= 1'b0;
            m_od  <= '0;
            m_oc  <= 0;
        end else begin
            int g;
            g = m_grant();
            if (g >= 0 && (!m_ov || or5) && v5[g[2:0]]) begin
                m_od <= 16'(d5 >> (g * 16));
                m_oc <= g;
                m_ov <= 1'b1;
                if (mode5) m_rr <= g;
            end else if (or5) begin
                m_ov <= 1'b0;
            end
            if (sel_load5 && sel_in5 < 3'd5) m_sel <= int'(sel_in5);
        end
    end

    always @(negedge clk) begin
        if (rst5_n && chk5_en) begin
            int g;
            logic [4:0] er;
            g  = m_grant();
            er = (g >= 0 && (!m_ov || or5)) ? 5'(32'd1 << g) : 5'd0;
            check("u5_in_ready",  32'(rdy5), 32'(er));
            check("u5_out_valid", 32'(ov5),  32'(m_ov));
            check("u5_out_data",  32'(od5),  32'(m_od));
            check("u5_out_chan",  32'(oc5),  32'(m_oc));
            check("u5_chan_range", 32'(oc5 < 3'd5), 32'd1);
        end
    end

    int exp_ch [4] = '{2, 5, 7, 2};

    initial begin
        rst8_n = 1'b0; rst5_n = 1'b0;
        d8 = '0; v8 = '0; mode8 = 1'b0; sel_load8 = 1'b0; sel_in8 = '0; or8 = 1'b0;
        d5 = '0; v5 = '0; mode5 = 1'b0; sel_load5 = 1'b0; sel_in5 = '0; or5 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("u8_rst_valid", 32'(ov8), 32'd0);
        check("u8_rst_data",  32'(od8), 32'd0);
        check("u8_rst_chan",  32'(oc8), 32'd0);
        @(negedge clk) rst8_n = 1'b1;
        step();

        // Fixed select of channel 5.
        mode8 = 1'b0; sel_load8 = 1'b1; sel_in8 = 3'd5; v8 = 8'h00; or8 = 1'b1; d8 = 8'h20;
        #1 check("t1_ready_old_sel", 32'(rdy8), 32'h01);
        step();
        sel_load8 = 1'b0; v8 = 8'hFF;
        #1 check("t1_ready_sel5", 32'(rdy8), 32'h20);
        step();
        check("t1_out_valid", 32'(ov8), 32'd1);
        check("t1_out_data",  32'(od8), 32'd1);
        check("t1_out_chan",  32'(oc8), 32'd5);

        // sel_load coincident with a transfer.
        sel_load8 = 1'b1; sel_in8 = 3'd3;
        #1 check("t4_ready_still5", 32'(rdy8), 32'h20);
        step();
        check("t4_old_chan", 32'(oc8), 32'd5);
        sel_load8 = 1'b0; d8 = 8'h08;
        #1 check("t4_ready_new3", 32'(rdy8), 32'h08);
        step();
        check("t4_new_chan", 32'(oc8), 32'd3);
        check("t4_new_data", 32'(od8), 32'd1);

        // Asynchronous reset while holding a word.
        or8 = 1'b0;
        step();
        check("t5_held_valid", 32'(ov8), 32'd1);
        check("t5_held_data",  32'(od8), 32'd1);
        #1 rst8_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(ov8), 32'd0);
        check("t5_rst_data",  32'(od8), 32'd0);
        check("t5_rst_chan",  32'(oc8), 32'd0);
        mode8 = 1'b1; v8 = 8'hFF; d8 = 8'h01; or8 = 1'b1;
        @(negedge clk) rst8_n = 1'b1;
        #1 check("t5_scan_ready0", 32'(rdy8), 32'h01);
        step();
        check("t5_scan_chan0", 32'(oc8), 32'd0);
        check("t5_scan_data",  32'(od8), 32'd1);

        // Scan sequence from reset over a sparse valid pattern.
        rst8_n = 1'b0;
        v8 = 8'b1010_0100; d8 = 8'h80; mode8 = 1'b1; or8 = 1'b1;
        @(negedge clk) rst8_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_scan_chan",  32'(oc8), 32'(exp_ch[i]));
            check("t2_scan_data",  32'(od8), (exp_ch[i] == 7) ? 32'd1 : 32'd0);
            check("t2_scan_valid", 32'(ov8), 32'd1);
        end

        // Backpressure then release with no bubble.
        or8 = 1'b0;
        #1 check("t3_ready_blocked", 32'(rdy8), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_chan",  32'(oc8),  32'd2);
            check("t3_hold_valid", 32'(ov8),  32'd1);
            check("t3_hold_ready", 32'(rdy8), 32'h00);
        end
        or8 = 1'b1;
        #1 check("t3_release_ready", 32'(rdy8), 32'h20);
        step();
        check("t3_next_chan",  32'(oc8), 32'd5);
        check("t3_next_valid", 32'(ov8), 32'd1);

        // Five-channel instance: out-of-range select ignored.
        @(negedge clk) begin rst5_n = 1'b1; chk5_en = 1'b1; end
        step();
        mode5 = 1'b0; sel_load5 = 1'b1; sel_in5 = 3'd2; v5 = 5'h00; or5 = 1'b1;
        d5 = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        step();
        sel_in5 = 3'd6;
        step();
        sel_load5 = 1'b0; v5 = 5'h1F;
        #1 check("t4_u5_ready_kept2", 32'(rdy5), 32'h04);
        step();
        check("t4_u5_chan", 32'(oc5), 32'd2);
        check("t4_u5_data", 32'(od5), 32'h3333);

        // Randomised regression against the model.
        for (int i = 0; i < 10000; i++) begin
            step();
            d5 = 80'({$urandom(), $urandom(), $urandom()});
            v5 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
            or5 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
            sel_load5 = ($urandom_range(0, 7) == 0);
            sel_in5 = 3'($urandom());
        end
        step();
        chk5_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
